// File: rtl/mt9v032_window.sv
// mt9v032_window: crops a rectangular window out of an MT9V032 line/frame-valid pixel stream.
// Optional per-frame geometry statistics are enabled by defining MT9V032_WINDOW_STATS_EN.
module mt9v032_window #(
    parameter int COL_START = 0,
    parameter int COL_COUNT = 752,
    parameter int ROW_START = 0,
    parameter int ROW_COUNT = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] px,
    input  logic       line_valid,
    input  logic       frame_valid,
    output logic [9:0] out_px,
    output logic       out_valid,
    output logic       out_sof,
    output logic       out_eol,
    output logic       out_eof,
    output logic [9:0] stat_width,
    output logic [8:0] stat_height,
    output logic       stat_err,
    output logic       stat_valid
);
    localparam logic [10:0] CS = 11'(COL_START);
    localparam logic [10:0] CL = 11'(COL_START + COL_COUNT - 1);
    localparam logic [9:0]  RS = 10'(ROW_START);
    localparam logic [9:0]  RL = 10'(ROW_START + ROW_COUNT - 1);
    logic       fv_d, primed, armed, q_d;
    logic [9:0] col_cnt;
    logic [8:0] row_cnt;
    logic       rise, q, line_end, hit;
    logic [9:0] col;
    logic [8:0] row;
    // primed keeps a frame_valid already high at reset release from looking like a rise
    always_comb begin
        rise     = frame_valid && !fv_d && primed;
        q        = line_valid && frame_valid && (armed || rise);
        line_end = q_d && !q;
        col      = rise ? '0 : col_cnt;
        row      = rise ? '0 : row_cnt;
        hit      = q && {1'b0, col} >= CS && {1'b0, col} <= CL
                     && {1'b0, row} >= RS && {1'b0, row} <= RL;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv_d      <= 1'b0;
            primed    <= 1'b0;
            armed     <= 1'b0;
            q_d       <= 1'b0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            out_px    <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            fv_d      <= frame_valid;
            primed    <= 1'b1;
            armed     <= armed || rise;
            q_d       <= q;
            col_cnt   <= q ? ((&col) ? col : col + 10'd1) : ((line_end || rise) ? '0 : col_cnt);
            row_cnt   <= rise ? '0 : ((line_end && !(&row_cnt)) ? row_cnt + 9'd1 : row_cnt);
            out_px    <= hit ? px : '0;
            out_valid <= hit;
            out_sof   <= hit && {1'b0, col} == CS && {1'b0, row} == RS;
            out_eol   <= hit && {1'b0, col} == CL;
            out_eof   <= hit && {1'b0, col} == CL && {1'b0, row} == RL;
        end
    end
`ifdef MT9V032_WINDOW_STATS_EN
    logic       fall, have_first, err, err_now;
    logic [9:0] last_len, first_len, len_now;
    logic [8:0] height_now;
    // a line ending on the frame_valid fall itself must be folded into that frame's stats
    always_comb begin
        fall       = fv_d && !frame_valid && armed;
        len_now    = line_end ? col_cnt : last_len;
        err_now    = err || (line_end && have_first && col_cnt != first_len);
        height_now = (line_end && !(&row_cnt)) ? row_cnt + 9'd1 : row_cnt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_first  <= 1'b0;
            err         <= 1'b0;
            last_len    <= '0;
            first_len   <= '0;
            stat_width  <= '0;
            stat_height <= '0;
            stat_err    <= 1'b0;
            stat_valid  <= 1'b0;
        end else begin
            have_first  <= rise ? 1'b0 : (have_first || line_end);
            err         <= rise ? 1'b0 : err_now;
            last_len    <= len_now;
            first_len   <= (line_end && !have_first) ? col_cnt : first_len;
            stat_valid  <= fall;
            stat_width  <= fall ? len_now : stat_width;
            stat_height <= fall ? height_now : stat_height;
            stat_err    <= fall ? err_now : stat_err;
        end
    end
`else
    assign stat_width  = '0;
    assign stat_height = '0;
    assign stat_err    = 1'b0;
    assign stat_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_mt9v032_window.sv
// tb_mt9v032_window: randomized and directed frames checked against a row/column window model.
module tb_mt9v032_window;
    localparam int CS = 2, CC = 4, RS = 1, RC = 2;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [9:0] px = '0;
    logic       line_valid = 1'b0, frame_valid = 1'b0;
    logic [9:0] out_px, stat_width;
    logic       out_valid, out_sof, out_eol, out_eof, stat_err, stat_valid;
    logic [8:0] stat_height;
    int checks = 0, failures = 0;
    int nv, ns, ne, nf;
    int lens[16];
    mt9v032_window #(.COL_START(CS), .COL_COUNT(CC), .ROW_START(RS), .ROW_COUNT(RC)) dut (
        .clk(clk), .rst_n(rst_n), .px(px), .line_valid(line_valid), .frame_valid(frame_valid),
        .out_px(out_px), .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol),
        .out_eof(out_eof), .stat_width(stat_width), .stat_height(stat_height),
        .stat_err(stat_err), .stat_valid(stat_valid)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step(input logic lv, input logic fv, input logic [9:0] p, input logic ev,
                        input logic [9:0] ep, input logic es, input logic ee, input logic ef,
                        input string tag);
        line_valid = lv; frame_valid = fv; px = p;
        @(posedge clk); #1;
        chk(tag, {18'd0, out_valid, out_px, out_sof, out_eol, out_eof}, {18'd0, ev, ep, es, ee, ef});
`ifndef MT9V032_WINDOW_STATS_EN
        chk("stats_tied", {11'd0, stat_width, stat_height, stat_err, stat_valid}, 32'd0);
`endif
        nv += int'(out_valid); ns += int'(out_sof); ne += int'(out_eol); nf += int'(out_eof);
    endtask
    task automatic idle(input logic lv, input logic fv, input string tag);
        step(lv, fv, 10'($urandom), 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, tag);
    endtask
    task automatic pix(input int r, input int c, input logic [9:0] v);
        logic w;
        w = r >= RS && r < RS + RC && c >= CS && c < CS + CC;
        step(1'b1, 1'b1, v, w, w ? v : 10'd0, w && r == RS && c == CS,
             w && c == CS + CC - 1, w && c == CS + CC - 1 && r == RS + RC - 1, "pixel");
    endtask
    task automatic drive_frame(input int n, input bit lv_rise, input bit lv_fall, input bit pat);
        int err;
        nv = 0; ns = 0; ne = 0; nf = 0;
        if (!lv_rise) idle(1'b0, 1'b1, "rise_idle");
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < lens[r]; c++) pix(r, c, pat ? 10'(r * 16 + c) : 10'($urandom));
            if (r < n - 1) repeat ($urandom_range(1, 2)) idle(1'b0, 1'b1, "hblank");
        end
        if (lv_fall) idle(1'b1, 1'b0, "fall_lv");
        else begin
            idle(1'b0, 1'b1, "vblank_pre");
            idle(1'b0, 1'b0, "fall");
        end
`ifdef MT9V032_WINDOW_STATS_EN
        err = 0;
        for (int r = 1; r < n; r++) if (lens[r] != lens[0]) err = 1;
        chk("stat_valid_hi", {31'd0, stat_valid}, 32'd1);
        chk("stat_geom", {12'd0, stat_width, stat_height, stat_err},
            {12'd0, 10'(lens[n - 1]), 9'(n), 1'(err)});
`endif
        idle(1'b0, 1'b0, "vblank");
`ifdef MT9V032_WINDOW_STATS_EN
        chk("stat_valid_lo", {31'd0, stat_valid}, 32'd0);
        chk("stat_hold", {12'd0, stat_width, stat_height, stat_err},
            {12'd0, 10'(lens[n - 1]), 9'(n), 1'(err)});
`endif
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {18'd0, out_valid, out_px, out_sof, out_eol, out_eof}, 32'd0);
        rst_n = 1'b1;
        repeat (2) idle(1'b0, 1'b0, "post_reset");
        // directed 8x4 frame with px = row*16+col
        for (int r = 0; r < 4; r++) lens[r] = 8;
        drive_frame(4, 1'b0, 1'b0, 1'b1);
        chk("win_count", nv, 8);
        chk("win_sof", ns, 1);
        chk("win_eol", ne, 2);
        chk("win_eof", nf, 1);
        // short line of 3 in the first window row: no eol, next line still counts as a new row
        lens[0] = 8; lens[1] = 3; lens[2] = 8; lens[3] = 8;
        drive_frame(4, 1'b0, 1'b0, 1'b1);
        chk("short_count", nv, 5);
        chk("short_eol", ne, 1);
        // line_valid activity outside frame_valid
        repeat (3) begin
            idle(1'b1, 1'b0, "lv_no_fv");
            idle(1'b0, 1'b0, "lv_no_fv");
        end
        // geometry with a mismatched middle line, then frame_valid rising with line_valid high
        lens[0] = 10; lens[1] = 10; lens[2] = 9; lens[3] = 10; lens[4] = 10;
        drive_frame(5, 1'b0, 1'b0, 1'b0);
        drive_frame(5, 1'b1, 1'b1, 1'b0);
        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int r = 0; r < n; r++) lens[r] = $urandom_range(1, 8);
            drive_frame(n, 1'(f[0]), 1'($urandom_range(0, 1)), 1'b0);
        end
        // asynchronous reset mid-line inside the window, released while frame_valid stays high
        idle(1'b0, 1'b1, "rst_rise");
        for (int c = 0; c < 8; c++) pix(0, c, 10'($urandom));
        idle(1'b0, 1'b1, "rst_gap");
        for (int c = 0; c < 4; c++) pix(1, c, 10'($urandom));
        #2 rst_n = 1'b0;
        #1 chk("async_clear", {18'd0, out_valid, out_px, out_sof, out_eol, out_eof}, 32'd0);
        idle(1'b1, 1'b1, "in_reset");
        idle(1'b1, 1'b1, "in_reset");
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            repeat (8) idle(1'b1, 1'b1, "unarmed");
            idle(1'b0, 1'b1, "unarmed_gap");
        end
        idle(1'b0, 1'b0, "unarmed_end");
        for (int r = 0; r < 3; r++) lens[r] = 7;
        drive_frame(3, 1'b0, 1'b0, 1'b0);
        chk("rearm_count", nv, 8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mt9v032_window.md
MT9V032_WINDOW -- requirements
Module: mt9v032_window

Interface
REQ-001 Parameter COL_START, default 0, first output column (0-based).
REQ-002 Parameter COL_COUNT, default 752, output columns per line (≥1).
REQ-003 Parameter ROW_START, default 0, first output row (0-based).
REQ-004 Parameter ROW_COUNT, default 480, output rows per frame (≥1).
REQ-005 Port clk, input, 1, pixel clock; all logic on rising edge.
REQ-006 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 Port px, input, 10, upstream pixel value.
REQ-008 Port line_valid, input, 1, upstream line-active level.
REQ-009 Port frame_valid, input, 1, upstream frame-active level.
REQ-010 Port out_px, output, 10, windowed pixel.
REQ-011 Port out_valid, output, 1, out_px holds a windowed pixel.
REQ-012 Port out_sof, output, 1, first pixel of window in frame.
REQ-013 Port out_eol, output, 1, last pixel of window row.
REQ-014 Port out_eof, output, 1, last pixel of window in frame.
REQ-015 Ports stat_width (10), stat_height (9), stat_err (1), stat_valid (1), outputs, per-frame geometry (present only per REQ-032).

Function
REQ-016 Qualified pixel: cycle with line_valid=1 and frame_valid=1; no other cycle shall advance col or emit output.
REQ-017 Column counter col (10 b): 0 at first qualified pixel of line, +1 per qualified pixel, saturates at 1023.
REQ-018 Line end: cycle where previous-cycle qualified and current not (line_valid fall, or frame_valid fall with line_valid high); col returns to 0.
REQ-019 Row counter row (9 b): cleared on frame_valid rise, +1 at each line end with ≥1 qualified pixel, saturates at 511.
REQ-020 In-window: COL_START ≤ col < COL_START+COL_COUNT and ROW_START ≤ row < ROW_START+ROW_COUNT.
REQ-021 Latency 1 cycle: out_px/out_valid register px and (qualified AND in-window); out_px=0 when out_valid=0.
REQ-022 out_sof=1 with out_valid when col=COL_START and row=ROW_START; else 0.
REQ-023 out_eol=1 with out_valid when col=COL_START+COL_COUNT-1; else 0.
REQ-024 out_eof=1 when out_eol=1 and row=ROW_START+ROW_COUNT-1; else 0.
REQ-025 Short line (ends before window end): no out_eol for that row; row still increments.
REQ-026 Short frame (frame_valid falls before last window row): no out_eof; counters clear on next frame_valid rise.
REQ-027 frame_valid rise while line_valid already high: that cycle is col 0, row 0.
REQ-028 Flow: no backpressure; output follows input every cycle.

Reset
REQ-029 rst_n=0 shall immediately clear col, row, edge-history, all outputs and stats to 0.
REQ-030 After rst_n release mid-frame, block shall emit nothing until next frame_valid rise.
REQ-031 Internal frame-armed flag: set on frame_valid rise, cleared by reset; REQ-016 additionally requires it set.

Configuration
REQ-032 Macro MT9V032_WINDOW_STATS_EN: defined -> stat_* implemented; undefined -> stat_* tied to 0 and stats logic omitted.
REQ-033 With macro: at each line end latch col length; stat_err set if any line length in frame differs from frame's first line length.
REQ-034 With macro: at frame_valid fall, stat_width=last line length, stat_height=row count, stat_err per REQ-033, stat_valid=1 for exactly one cycle; values hold until next frame end.

Verification
REQ-035 Defaults, 752x480 frame -> 360960 out_valid, one out_sof at first px, 480 out_eol, one out_eof at final px, latency 1.
REQ-036 COL_START=2, COL_COUNT=4, ROW_START=1, ROW_COUNT=2, 8x4 frame px=row*16+col -> out_px 0x12,0x13,0x14,0x15,0x22..0x25; sof on 0x12, eol on 0x15/0x25, eof on 0x25.
REQ-037 Line of 3 px with COL_START=2, COL_COUNT=4 -> one out_valid, no out_eol; next line row=+1.
REQ-038 rst_n low mid-line, release mid-frame -> outputs 0 immediately, no out_valid until next frame_valid rise.
REQ-039 Stats on, 10x5 frame with line 3 length 9 -> stat_valid one cycle after frame_valid fall, stat_width=10, stat_height=5, stat_err=1.
REQ-040 Line_valid toggling while frame_valid=0 -> no out_valid, row unchanged.
